// File: rtl/matrix_multiplication.sv
// -----------------------------------------------------------------------------
// matrix_multiplication
//
// Serial 3x3 matrix multiplier for 8-bit unsigned elements, computing
// C = A x B. It uses one multiply-accumulate unit, so it produces one product
// per clock and needs 27 compute cycles for a full result. It is meant to sit
// beside a controller that loads the operands, pulses start and waits for done.
//
// Ports
//   clk     in   1   sole clock, rising edge
//   reset   in   1   synchronous, active-high reset
//   start   in   1   begin a multiplication (accepted in IDLE or DONE)
//   A_flat  in  72   matrix A, row-major, A[r][c] at [71-8*(3r+c) -: 8]
//   B_flat  in  72   matrix B, same packing
//   C_flat  out 72   result matrix C, same packing
//   done    out  1   high while a completed result is held on C_flat
// -----------------------------------------------------------------------------
module matrix_multiplication (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [71:0] A_flat,
    input  logic [71:0] B_flat,
    output logic [71:0] C_flat,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [71:0] a_reg;
    logic [71:0] b_reg;
    logic [1:0]  i_idx;
    logic [1:0]  j_idx;
    logic [1:0]  k_idx;
    // The worst case is 3 * 255 * 255 = 195075, which fits in 18 bits.
    logic [17:0] acc;
    logic [7:0]  c_mat [0:8];

    logic [7:0]  a_mat [0:8];
    logic [7:0]  b_mat [0:8];
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic [3:0]  c_sel;
    logic [15:0] product;
    logic [17:0] sum;
    logic        start_accept;
    logic        last_mac;

    // Unpack the captured operands and repack the result elements. Element n
    // in row-major order lives in the byte that starts at bit 71-8n.
    genvar n;
    generate
        for (n = 0; n < 9; n++) begin : g_unpack
            assign a_mat[n]             = a_reg[71-8*n -: 8];
            assign b_mat[n]             = b_reg[71-8*n -: 8];
            assign C_flat[71-8*n -: 8]  = c_mat[n];
        end
    endgenerate

    // MAC datapath: A[i][k] * B[k][j] added to the running dot product.
    assign a_sel   = ({2'b00, i_idx} * 4'd3) + {2'b00, k_idx};
    assign b_sel   = ({2'b00, k_idx} * 4'd3) + {2'b00, j_idx};
    assign c_sel   = ({2'b00, i_idx} * 4'd3) + {2'b00, j_idx};
    assign product = {8'b0, a_mat[a_sel]} * {8'b0, b_mat[b_sel]};
    assign sum     = acc + {2'b00, product};

    // A start is honoured only when no multiplication is in flight, so a
    // start pulse during COMPUTE is simply dropped.
    assign start_accept = start && ((state == IDLE) || (state == DONE));
    assign last_mac     = (state == COMPUTE) && (i_idx == 2'd2) &&
                          (j_idx == 2'd2) && (k_idx == 2'd2);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_accept) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (last_mac) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start_accept) begin
                    state_next = COMPUTE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: operand capture, index walk, accumulator, result
    // elements and the done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            acc   <= '0;
            done  <= 1'b0;
            for (int e = 0; e < 9; e++) begin
                c_mat[e] <= '0;
            end
        end else if (start_accept) begin
            a_reg <= A_flat;
            b_reg <= B_flat;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            acc   <= '0;
            done  <= 1'b0;
            for (int e = 0; e < 9; e++) begin
                c_mat[e] <= '0;
            end
        end else if (state == COMPUTE) begin
            if (k_idx != 2'd2) begin
                acc   <= sum;
                k_idx <= k_idx + 2'd1;
            end else begin
                // Dot product finished: keep only the low byte (mod 256)
                // and step to the next element in row-major order.
                c_mat[c_sel] <= sum[7:0];
                acc          <= '0;
                k_idx        <= '0;
                if (j_idx == 2'd2) begin
                    j_idx <= '0;
                    if (i_idx == 2'd2) begin
                        i_idx <= '0;
                        done  <= 1'b1;
                    end else begin
                        i_idx <= i_idx + 2'd1;
                    end
                end else begin
                    j_idx <= j_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_multiplication.sv
// -----------------------------------------------------------------------------
// tb_matrix_multiplication
//
// Directed bench for matrix_multiplication. Each scenario task drives its own
// stimulus and compares against hand-computed matrices.
// -----------------------------------------------------------------------------
module tb_matrix_multiplication;

    logic        clk;
    logic        reset;
    logic        start;
    logic [71:0] A_flat;
    logic [71:0] B_flat;
    logic [71:0] C_flat;
    logic        done;

    int checks;
    int failures;

    // Operand and result matrices, row-major, one byte per element.
    localparam logic [71:0] M_1_TO_9  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    localparam logic [71:0] M_9_TO_1  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [71:0] M_IDENT   = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    localparam logic [71:0] M_TWO_I   = {8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2};
    localparam logic [71:0] M_ALL_FF  = {9{8'hFF}};
    localparam logic [71:0] C_FIRST   = {8'd30, 8'd24, 8'd18, 8'd84, 8'd69, 8'd54, 8'd138, 8'd114, 8'd90};
    localparam logic [71:0] C_TRUNC   = {9{8'd3}};
    localparam logic [71:0] C_TWO_B   = {8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16, 8'd18};
    localparam logic [71:0] C_SQUARE  = {8'd30, 8'd36, 8'd42, 8'd66, 8'd81, 8'd96, 8'd102, 8'd126, 8'd150};

    matrix_multiplication dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A_flat (A_flat),
        .B_flat (B_flat),
        .C_flat (C_flat),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands and hold start for exactly one rising edge (the
    // accepting edge E0). Called 1 time unit after a rising edge; returns
    // 1 time unit after E0.
    task automatic start_op(input logic [71:0] a, input logic [71:0] b);
        A_flat = a;
        B_flat = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Count rising edges until done is seen, giving up after budget edges.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!done && cycles < budget);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        A_flat = '0;
        B_flat = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (C_flat !== 72'd0) begin
            failures++;
            $display("[TB] FAIL reset_c: got %h expected 0", C_flat);
        end
    endtask

    task automatic test_basic();
        int cycles;
        start_op(M_1_TO_9, M_9_TO_1);
        // Operands on the bus change right away; the captured copy must be used.
        A_flat = M_ALL_FF;
        B_flat = M_ALL_FF;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_done_low_e0: got %b expected 0", done);
        end
        wait_done(40, cycles);
        checks++;
        if (cycles !== 27) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d expected 27", cycles);
        end
        checks++;
        if (C_flat !== C_FIRST) begin
            failures++;
            $display("[TB] FAIL basic_result: got %h expected %h", C_flat, C_FIRST);
        end
    endtask

    task automatic test_identity_hold();
        int cycles;
        int held_bad;
        start_op(M_IDENT, M_1_TO_9);
        wait_done(40, cycles);
        checks++;
        if (cycles !== 27) begin
            failures++;
            $display("[TB] FAIL ident_latency: got %0d expected 27", cycles);
        end
        checks++;
        if (C_flat !== M_1_TO_9) begin
            failures++;
            $display("[TB] FAIL ident_result: got %h expected %h", C_flat, M_1_TO_9);
        end
        held_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1 || C_flat !== M_1_TO_9) begin
                held_bad++;
            end
        end
        checks++;
        if (held_bad !== 0) begin
            failures++;
            $display("[TB] FAIL ident_hold: got %0d bad idle cycles expected 0 (done=%b C=%h)",
                     held_bad, done, C_flat);
        end
    endtask

    task automatic test_truncation();
        int cycles;
        start_op(M_ALL_FF, M_ALL_FF);
        wait_done(40, cycles);
        checks++;
        if (cycles !== 27) begin
            failures++;
            $display("[TB] FAIL trunc_latency: got %0d expected 27", cycles);
        end
        checks++;
        if (C_flat !== C_TRUNC) begin
            failures++;
            $display("[TB] FAIL trunc_result: got %h expected %h", C_flat, C_TRUNC);
        end
    endtask

    task automatic test_ignore_start();
        int cycles;
        start_op(M_1_TO_9, M_9_TO_1);
        cycles = 0;
        while (!done && cycles < 40) begin
            if (cycles == 10) begin
                A_flat = M_ALL_FF;
                B_flat = M_IDENT;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        checks++;
        if (cycles !== 27) begin
            failures++;
            $display("[TB] FAIL ignore_latency: got %0d expected 27", cycles);
        end
        checks++;
        if (C_flat !== C_FIRST) begin
            failures++;
            $display("[TB] FAIL ignore_result: got %h expected %h", C_flat, C_FIRST);
        end
    endtask

    task automatic test_reset_abort();
        int cycles;
        int seen_done;
        start_op(M_1_TO_9, M_9_TO_1);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        // By E14 elements C00..C03 are written: first byte is 30.
        checks++;
        if (C_flat[71:64] !== 8'd30) begin
            failures++;
            $display("[TB] FAIL abort_partial: got %0d expected 30", C_flat[71:64]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (C_flat !== 72'd0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_clear: got C=%h done=%b expected C=0 done=0", C_flat, done);
        end
        seen_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || C_flat !== 72'd0) begin
                seen_done = 1;
            end
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("[TB] FAIL abort_stays_idle: got activity=%0d expected 0", seen_done);
        end
        // Reset and start on the same edge: reset wins, block stays idle.
        A_flat = M_1_TO_9;
        B_flat = M_9_TO_1;
        reset  = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        start  = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (done !== 1'b0 || C_flat !== 72'd0) begin
            failures++;
            $display("[TB] FAIL reset_beats_start: got C=%h done=%b expected C=0 done=0",
                     C_flat, done);
        end
        start_op(M_TWO_I, M_1_TO_9);
        wait_done(40, cycles);
        checks++;
        if (cycles !== 27) begin
            failures++;
            $display("[TB] FAIL after_abort_latency: got %0d expected 27", cycles);
        end
        checks++;
        if (C_flat !== C_TWO_B) begin
            failures++;
            $display("[TB] FAIL after_abort_result: got %h expected %h", C_flat, C_TWO_B);
        end
    endtask

    // Start on the edge right after done rises (sits in DONE from the
    // previous scenario): done must drop on the accepting edge.
    task automatic test_back_to_back();
        int cycles;
        start_op(M_1_TO_9, M_1_TO_9);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_done_falls: got %b expected 0", done);
        end
        wait_done(40, cycles);
        checks++;
        if (cycles !== 27) begin
            failures++;
            $display("[TB] FAIL b2b_latency: got %0d expected 27", cycles);
        end
        checks++;
        if (C_flat !== C_SQUARE) begin
            failures++;
            $display("[TB] FAIL b2b_result: got %h expected %h", C_flat, C_SQUARE);
        end
        // Immediately chain another operation.
        start_op(M_1_TO_9, M_9_TO_1);
        wait_done(40, cycles);
        checks++;
        if (cycles !== 27 || C_flat !== C_FIRST) begin
            failures++;
            $display("[TB] FAIL b2b_second: got cycles=%0d C=%h expected cycles=27 C=%h",
                     cycles, C_flat, C_FIRST);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        A_flat   = '0;
        B_flat   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_identity_hold();
        test_truncation();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
